// File: rtl/ma_pkg.sv
// Shared types and default sizes for the MA load arbiter.
// Imported by the interface, the round-robin picker and the top.
package ma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

endpackage

// File: rtl/ma_load_arb_if.sv
// Requester-side bus of the MA load arbiter.
// master drives requests; slave is the arbiter.
interface ma_load_arb_if
  import ma_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
);

  logic [NREQ-1:0]         req;
  logic [NREQ*W-1:0]       din;
  logic                    ld;
  logic [W-1:0]            da;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         ack;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] last_src;

  modport master (
    output req, din,
    input  ld, da, gnt, ack, busy, last_src
  );

  modport slave (
    input  req, din,
    output ld, da, gnt, ack, busy, last_src
  );

endinterface

// File: rtl/ma_load_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or above ptr, wrapping past NREQ-1.
module rr_pick
  import ma_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  int c;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = (int'(ptr) + i) % NREQ;
      if (req[c]) begin
        valid = 1'b1;
        idx   = PW'(c);
      end
    end
  end

endmodule

// File: rtl/ma_load_arb.sv
// Round-robin arbiter loading one requester's data
// into the shared MA register: IDLE -> LOAD -> ACK.
module ma_load_arb
  import ma_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input logic          clk,
  input logic          clr,
  ma_load_arb_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [PW-1:0]   last_q, last_d;
  logic            ld_q, ld_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    da_q, da_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic          pick_v;
  logic [PW-1:0] pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    last_d  = last_q;
    da_d    = da_q;
    gnt_d   = gnt_q;
    ld_d    = 1'b0;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_v) begin
          state_d         = LOAD;
          win_d           = pick_idx;
          da_d            = bus.din[int'(pick_idx)*W +: W];
          gnt_d[pick_idx] = 1'b1;
          ld_d            = 1'b1;
        end
      end
      LOAD: begin
        state_d = ACK;
        ack_d   = gnt_q;
        last_d  = win_q;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Reset wins over everything, including an in-flight load.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      last_q  <= '0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      da_q    <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      last_q  <= last_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      da_q    <= da_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ld       = ld_q;
  assign bus.da       = da_q;
  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.last_src = last_q;

endmodule

// File: tb/tb_ma_load_arb.sv
// Directed vector bench for ma_load_arb plus
// round-robin ordering and fairness sequences.
module tb_ma_load_arb;

  localparam logic [15:0] D = 16'hC95A;
  localparam logic [15:0] F = 16'hFFFF;

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [15:0] din;
    logic        ld;
    logic [3:0]  da;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  last;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vt[24];

  ma_load_arb_if #(.NREQ(4), .W(4)) bus ();

  ma_load_arb #(.NREQ(4), .W(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic c, input logic [3:0] r,
                      input logic [15:0] d);
    clr     = c;
    bus.req = r;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input string nm, input logic [3:0] r,
                         input bit drop, input logic [3:0] g0,
                         input logic [3:0] g1, input logic [3:0] g2,
                         input logic [3:0] g3);
    logic [3:0] exp_g[4];
    logic [3:0] got_g[4];
    int         lc[4];
    int         n;
    exp_g[0] = g0; exp_g[1] = g1;
    exp_g[2] = g2; exp_g[3] = g3;
    n = 0;
    step(1'b1, r, D);
    step(1'b1, r, D);
    clr     = 1'b0;
    bus.req = r;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      checks++;
      if (!$onehot0(bus.gnt) || !$onehot0(bus.ack) ||
          (bus.ld && !bus.busy)) begin
        errors++;
        $display("FAIL %s inv cyc%0d: gnt=%b ack=%b ld=%b busy=%b",
                 nm, cyc, bus.gnt, bus.ack, bus.ld, bus.busy);
      end
      if (bus.ld && n < 4) begin
        got_g[n] = bus.gnt;
        lc[n]    = cyc;
        n++;
      end
      if (drop && bus.ack != 4'b0) bus.req = bus.req & ~bus.ack;
      if (n == 4 && bus.ack != 4'b0) break;
    end
    checks++;
    if (n < 4) begin
      errors++;
      $display("FAIL %s timeout: loads=%0d required 4", nm, n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_g[k] !== exp_g[k]) begin
          errors++;
          $display("FAIL %s grant%0d: got %b required %b",
                   nm, k, got_g[k], exp_g[k]);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (lc[k] - lc[k-1] != 3) begin
          errors++;
          $display("FAIL %s spacing%0d: got %0d required 3",
                   nm, k, lc[k] - lc[k-1]);
        end
      end
    end
    bus.req = 4'b0;
  endtask

  initial begin
    bus.req = 4'hF;
    bus.din = D;
    // clr,req,din, ld,da,gnt,ack,busy,last
    vt[0]  = '{1'b1, 4'hF, D, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0};
    vt[1]  = '{1'b1, 4'hF, D, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0};
    vt[2]  = '{1'b0, 4'h4, D, 1'b1, 4'h9, 4'h4, 4'h0, 1'b1, 2'd0};
    vt[3]  = '{1'b0, 4'h4, D, 1'b0, 4'h9, 4'h4, 4'h4, 1'b1, 2'd2};
    vt[4]  = '{1'b0, 4'h0, D, 1'b0, 4'h9, 4'h0, 4'h0, 1'b0, 2'd2};
    vt[5]  = '{1'b0, 4'h0, D, 1'b0, 4'h9, 4'h0, 4'h0, 1'b0, 2'd2};
    vt[6]  = '{1'b0, 4'hF, D, 1'b1, 4'hC, 4'h8, 4'h0, 1'b1, 2'd2};
    vt[7]  = '{1'b0, 4'hF, D, 1'b0, 4'hC, 4'h8, 4'h8, 1'b1, 2'd3};
    vt[8]  = '{1'b0, 4'h7, D, 1'b0, 4'hC, 4'h0, 4'h0, 1'b0, 2'd3};
    vt[9]  = '{1'b0, 4'h7, D, 1'b1, 4'hA, 4'h1, 4'h0, 1'b1, 2'd3};
    vt[10] = '{1'b0, 4'h7, D, 1'b0, 4'hA, 4'h1, 4'h1, 1'b1, 2'd0};
    vt[11] = '{1'b0, 4'h6, D, 1'b0, 4'hA, 4'h0, 4'h0, 1'b0, 2'd0};
    vt[12] = '{1'b0, 4'h6, D, 1'b1, 4'h5, 4'h2, 4'h0, 1'b1, 2'd0};
    vt[13] = '{1'b0, 4'h6, F, 1'b0, 4'h5, 4'h2, 4'h2, 1'b1, 2'd1};
    vt[14] = '{1'b0, 4'h4, F, 1'b0, 4'h5, 4'h0, 4'h0, 1'b0, 2'd1};
    vt[15] = '{1'b0, 4'h4, D, 1'b1, 4'h9, 4'h4, 4'h0, 1'b1, 2'd1};
    vt[16] = '{1'b1, 4'h4, D, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0};
    vt[17] = '{1'b0, 4'h0, D, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0};
    vt[18] = '{1'b0, 4'hA, D, 1'b1, 4'h5, 4'h2, 4'h0, 1'b1, 2'd0};
    vt[19] = '{1'b0, 4'h8, D, 1'b0, 4'h5, 4'h2, 4'h2, 1'b1, 2'd1};
    vt[20] = '{1'b0, 4'h8, D, 1'b0, 4'h5, 4'h0, 4'h0, 1'b0, 2'd1};
    vt[21] = '{1'b0, 4'h8, D, 1'b1, 4'hC, 4'h8, 4'h0, 1'b1, 2'd1};
    vt[22] = '{1'b0, 4'h0, D, 1'b0, 4'hC, 4'h8, 4'h8, 1'b1, 2'd3};
    vt[23] = '{1'b0, 4'h0, D, 1'b0, 4'hC, 4'h0, 4'h0, 1'b0, 2'd3};

    for (int i = 0; i < 24; i++) begin
      step(vt[i].clr, vt[i].req, vt[i].din);
      checks++;
      if (bus.ld !== vt[i].ld || bus.da !== vt[i].da ||
          bus.gnt !== vt[i].gnt || bus.ack !== vt[i].ack ||
          bus.busy !== vt[i].busy || bus.last_src !== vt[i].last) begin
        errors++;
        $display("FAIL vec%0d: got ld=%b da=%h gnt=%b ack=%b busy=%b last=%0d required ld=%b da=%h gnt=%b ack=%b busy=%b last=%0d",
                 i, bus.ld, bus.da, bus.gnt, bus.ack, bus.busy,
                 bus.last_src, vt[i].ld, vt[i].da, vt[i].gnt,
                 vt[i].ack, vt[i].busy, vt[i].last);
      end
    end

    run_seq("rr_all", 4'hF, 1'b1, 4'h1, 4'h2, 4'h4, 4'h8);
    run_seq("fair03", 4'h9, 1'b0, 4'h1, 4'h8, 4'h1, 4'h8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ma_load_arb.md
MA_LOAD_ARB -- requirements
Module: ma_load_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the MA register.
REQ-002 Parameter W, default 4, data width of the MA register.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 req  input  NREQ  per-requester load request, level-held until acked.
REQ-006 din  input  NREQ*W  packed requester data; requester i occupies bits [i*W +: W].
REQ-007 ld  output  1  load strobe to the MA register, registered.
REQ-008 da  output  W  data to the MA register, registered; valid while ld=1.
REQ-009 gnt  output  NREQ  one-hot grant, registered.
REQ-010 ack  output  NREQ  one-hot one-cycle completion pulse, registered.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 last_src  output  $clog2(NREQ)  index of the most recently completed requester.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, LOAD and ACK.
REQ-014 In IDLE with req != 0, the FSM SHALL pick a winner round-robin, searching upward from ptr and wrapping at NREQ-1.
REQ-015 On the IDLE->LOAD edge, the block SHALL capture din of the winner into da, set gnt[winner]=1 and set ld=1.
REQ-016 In LOAD, ld SHALL be high for exactly one cycle, then the FSM SHALL go to ACK.
REQ-017 On the LOAD->ACK edge: ld=0, gnt held, ack[winner]=1 for one cycle, last_src=winner, ptr=(winner+1) mod NREQ.
REQ-018 On the ACK->IDLE edge: gnt=0, ack=0; da SHALL hold its last value.
REQ-019 Latency: req sampled high in IDLE at edge N -> ld=1 after edge N, ack=1 after edge N+1, IDLE after edge N+2; peak throughput is one load per 3 cycles.
REQ-020 Changes to din or req after the capture edge SHALL NOT affect da or the ongoing transaction; a req dropped during LOAD/ACK still completes.
REQ-021 A req still high in the first IDLE cycle after its ack SHALL be treated as a new request, subject to round-robin.
REQ-022 With req == 0 in IDLE, the FSM SHALL stay in IDLE with ld=0, gnt=0, ack=0.
REQ-023 At most one bit of gnt and of ack SHALL be set at any time; ld SHALL never be high outside LOAD.

Reset
REQ-024 clr=1 at a rising edge SHALL force state=IDLE, ptr=0, ld=0, da=0, gnt=0, ack=0, busy=0, last_src=0.
REQ-025 clr asserted mid-transaction (LOAD or ACK) SHALL abort it with no ack issued; clr SHALL take priority over all other inputs.

Structure
REQ-026 Package ma_pkg SHALL hold the state enum (IDLE, LOAD, ACK) and the default NREQ and W constants.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs valid, idx).
REQ-028 All outputs SHALL come directly from flops; there SHALL be no combinational path from req/din to any output.

Verification
REQ-029 clr=1 for 2 cycles with req=4'b1111 -> all outputs 0, busy=0 throughout.
REQ-030 After clr, req=4'b0100, din[11:8]=4'd9 -> ld=1 and da=9 next cycle, ack=4'b0100 the following cycle, last_src=2.
REQ-031 After clr, req=4'b1111 held, each requester dropping on its ack -> grant order 0,1,2,3, loads spaced exactly 3 cycles apart.
REQ-032 req=4'b0001 held continuously with req=4'b1000 -> grants alternate 0,3,0,3 (no starvation).
REQ-033 req=4'b0010, din changed from 4'd5 to 4'd12 one cycle after capture -> da stays 5, ack still issued.
REQ-034 clr=1 during LOAD -> next cycle ld=0, gnt=0, no ack pulse, state IDLE, ptr=0.
